// File: rtl/sreg_pkg.sv
// Shared sizes and state encoding for the 42-bit pixel/config shift-register sequencer.
package sreg_pkg;

    localparam int SREG_W = 42;
    localparam int TAP_W  = SREG_W / 2;
    localparam int CNT_W  = $clog2(SREG_W);

    typedef enum logic [1:0] {
        IDLE,
        RD_SHIFT,
        CFG_SHIFT
    } state_t;

endpackage

// File: rtl/sreg_ctrl.sv
// Sequencer for the dual-tap pixel/config shift register: arbitrates pixel readout
// (parallel load, shift, deserialise both taps) against MSB-first config writes.
module sreg_ctrl
    import sreg_pkg::*;
(
    input  logic              sclk,
    input  logic              rst,
    input  logic              rd_start,
    input  logic              cfg_start,
    input  logic [SREG_W-1:0] cfg_data,
    input  logic [1:0]        sreg_out,
    output logic              shift,
    output logic              serial_in,
    output logic              write_cfg,
    output logic              busy,
    output logic [SREG_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              cfg_done
);

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(TAP_W - 1);
    localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(SREG_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rd_pend;
    logic [SREG_W-1:0] cfg_sr;
    logic [TAP_W-1:0]  hi;
    logic [TAP_W-1:0]  lo;
    logic [TAP_W-1:0]  hi_next;
    logic [TAP_W-1:0]  lo_next;

    // Each tap delivers its bits MSB first, so shifting left rebuilds each half in order.
    assign hi_next = {hi[TAP_W-2:0], sreg_out[1]};
    assign lo_next = {lo[TAP_W-2:0], sreg_out[0]};

    // Outside IDLE the shift register always shifts; in IDLE it reloads pixel_in every edge.
    assign busy      = (state != IDLE);
    assign shift     = busy;
    assign serial_in = (state == CFG_SHIFT) && cfg_sr[CFG_LAST - cnt];
    assign write_cfg = (state == CFG_SHIFT) && (cnt == CFG_LAST);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_pend  <= 1'b0;
            cfg_sr   <= '0;
            hi       <= '0;
            lo       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
            rd_valid <= 1'b0;
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        cfg_sr  <= cfg_data;
                        cnt     <= '0;
                        rd_pend <= rd_pend | rd_start;
                        state   <= CFG_SHIFT;
                    end else if (rd_start || rd_pend) begin
                        cnt     <= '0;
                        rd_pend <= 1'b0;
                        state   <= RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    hi <= hi_next;
                    lo <= lo_next;
                    if (rd_start) rd_pend <= 1'b1;
                    if (cnt == RD_LAST) begin
                        rd_data  <= {hi_next, lo_next};
                        rd_valid <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                CFG_SHIFT: begin
                    if (rd_start) rd_pend <= 1'b1;
                    if (cnt == CFG_LAST) begin
                        cfg_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sreg_ctrl.sv
// Bench for sreg_ctrl: behavioural shift register plus a transaction-level reference model
// compared on every cycle, with literal latency/data checks on the directed scenarios.
module tb_sreg_ctrl;
    import sreg_pkg::*;

    localparam int OP_NONE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_CFG  = 2;

    logic              sclk = 1'b0;
    logic              rst;
    logic              rd_start;
    logic              cfg_start;
    logic [SREG_W-1:0] cfg_data;
    logic [1:0]        sreg_out;
    logic              shift;
    logic              serial_in;
    logic              write_cfg;
    logic              busy;
    logic [SREG_W-1:0] rd_data;
    logic              rd_valid;
    logic              cfg_done;
    logic [SREG_W-1:0] pixel_in;

    int n_checks = 0;
    int n_errors = 0;
    int n_rdv    = 0;
    int n_cfgd   = 0;
    int n_wcfg   = 0;
    bit chk_en   = 1'b0;

    sreg_ctrl dut (
        .sclk      (sclk),
        .rst       (rst),
        .rd_start  (rd_start),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .sreg_out  (sreg_out),
        .shift     (shift),
        .serial_in (serial_in),
        .write_cfg (write_cfg),
        .busy      (busy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .cfg_done  (cfg_done)
    );

    always #5 sclk = ~sclk;

    // Behavioural shift register: parallel load when not shifting, config latched on write_cfg.
    logic [SREG_W-1:0] sreg    = '0;
    logic [SREG_W-1:0] cfg_out = '0;
    always @(posedge sclk) begin
        if (write_cfg) cfg_out <= {sreg[SREG_W-2:0], serial_in};
        if (shift) sreg <= {sreg[SREG_W-2:0], serial_in};
        else       sreg <= pixel_in;
    end
    assign sreg_out = {sreg[SREG_W-1], sreg[TAP_W-1]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation at a time, tracked as (kind, cycles elapsed).
    int                m_op;
    int                m_idx;
    bit                m_pend;
    logic [SREG_W-1:0] m_cfg;
    logic [SREG_W-1:0] m_pix;
    logic [SREG_W-1:0] m_rd_data;
    bit                m_rd_valid;
    bit                m_cfg_done;

    function automatic int op_len(input int op);
        return (op == OP_RD) ? TAP_W : SREG_W;
    endfunction

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            m_op       <= OP_NONE;
            m_idx      <= 0;
            m_pend     <= 1'b0;
            m_rd_data  <= '0;
            m_rd_valid <= 1'b0;
            m_cfg_done <= 1'b0;
        end else begin
            m_rd_valid <= 1'b0;
            m_cfg_done <= 1'b0;
            if (m_op == OP_NONE) begin
                if (cfg_start) begin
                    m_op  <= OP_CFG;
                    m_idx <= 0;
                    m_cfg <= cfg_data;
                    if (rd_start) m_pend <= 1'b1;
                end else if (rd_start || m_pend) begin
                    m_op   <= OP_RD;
                    m_idx  <= 0;
                    m_pend <= 1'b0;
                    m_pix  <= pixel_in;
                end
            end else begin
                if (rd_start) m_pend <= 1'b1;
                if (m_idx == op_len(m_op) - 1) begin
                    m_op <= OP_NONE;
                    if (m_op == OP_RD) begin
                        m_rd_data  <= m_pix;
                        m_rd_valid <= 1'b1;
                    end else begin
                        m_cfg_done <= 1'b1;
                    end
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge sclk) begin : compare
        logic e_busy;
        logic e_sin;
        logic e_wcfg;
        if (chk_en) begin
            e_busy = (m_op != OP_NONE);
            e_sin  = (m_op == OP_CFG) ? m_cfg[SREG_W-1-m_idx] : 1'b0;
            e_wcfg = (m_op == OP_CFG) && (m_idx == SREG_W - 1);
            check("busy", 64'(busy), 64'(e_busy));
            check("shift", 64'(shift), 64'(e_busy));
            check("serial_in", 64'(serial_in), 64'(e_sin));
            check("write_cfg", 64'(write_cfg), 64'(e_wcfg));
            check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
            check("cfg_done", 64'(cfg_done), 64'(m_cfg_done));
            check("rd_data", 64'(rd_data), 64'(m_rd_data));
        end
        if (rd_valid)  n_rdv++;
        if (cfg_done)  n_cfgd++;
        if (write_cfg) n_wcfg++;
    end

    task automatic issue(input bit rd, input bit cfg);
        @(negedge sclk);
        rd_start  = rd;
        cfg_start = cfg;
        @(negedge sclk);
        rd_start  = 1'b0;
        cfg_start = 1'b0;
    endtask

    // Samples are numbered from the acceptance edge (sample 1 follows it); lat stays -1 on timeout.
    task automatic wait_for(input bit for_cfg, input int base, input int max,
                            output int lat, output int wcfg_at);
        lat     = -1;
        wcfg_at = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge sclk);
            if (write_cfg && wcfg_at < 0) wcfg_at = base + i;
            if (for_cfg ? cfg_done : rd_valid) begin
                lat = base + i;
                return;
            end
        end
    endtask

    initial begin
        int                lat;
        int                wat;
        int                cnt0;
        int                cnt1;
        logic [SREG_W-1:0] cfg_keep;

        rst       = 1'b0;
        rd_start  = 1'b0;
        cfg_start = 1'b0;
        cfg_data  = '0;
        pixel_in  = '0;
        #3 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_shift", 64'(shift), 64'd0);
        check("rst_write_cfg", 64'(write_cfg), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_cfg_done", 64'(cfg_done), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        repeat (2) @(negedge sclk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single readout of an alternating pattern.
        pixel_in = 42'h2AA_AAAA_AAAA;
        issue(1'b1, 1'b0);
        wait_for(1'b0, 1, 40, lat, wat);
        check("rd_latency", 64'(lat), 64'd22);
        check("rd_word", 64'(rd_data), 64'h2AA_AAAA_AAAA);
        repeat (3) @(negedge sclk);

        // Config write: write_cfg seen at sample 42 takes effect on edge 43.
        cnt0     = n_wcfg;
        cfg_data = 42'h3FF_0000_1234;
        issue(1'b0, 1'b1);
        cfg_data = '0;
        wait_for(1'b1, 1, 60, lat, wat);
        check("cfg_latency", 64'(lat), 64'd43);
        check("write_cfg_at", 64'(wat), 64'd42);
        @(negedge sclk);
        check("write_cfg_count", 64'(n_wcfg - cnt0), 64'd1);
        check("cfg_out", 64'(cfg_out), 64'h3FF_0000_1234);

        // Simultaneous requests: config first, one idle cycle, then the readout.
        pixel_in = 42'h155_5555_5555;
        cfg_data = 42'h0AB_CDEF_0123;
        issue(1'b1, 1'b1);
        wait_for(1'b1, 1, 60, lat, wat);
        check("both_cfg_latency", 64'(lat), 64'd43);
        check("both_idle_gap", 64'(busy), 64'd0);
        wait_for(1'b0, 43, 40, lat, wat);
        check("both_rd_latency", 64'(lat), 64'd65);
        check("both_rd_word", 64'(rd_data), 64'h155_5555_5555);
        check("both_cfg_out", 64'(cfg_out), 64'h0AB_CDEF_0123);
        repeat (3) @(negedge sclk);

        // Three readout requests during a config collapse to a single queued readout.
        cnt0     = n_rdv;
        pixel_in = 42'h3C3_C3C3_C3C3;
        issue(1'b0, 1'b1);
        for (int s = 2; s <= 20; s++) begin
            @(negedge sclk);
            rd_start = (s % 5 == 0) && (s < 20);
        end
        wait_for(1'b1, 20, 40, lat, wat);
        check("queue_cfg_latency", 64'(lat), 64'd43);
        wait_for(1'b0, 43, 40, lat, wat);
        check("queue_rd_latency", 64'(lat), 64'd65);
        repeat (40) @(negedge sclk);
        check("queue_rd_count", 64'(n_rdv - cnt0), 64'd1);

        // Config request during a readout is dropped.
        cnt0 = n_cfgd;
        cnt1 = n_wcfg;
        issue(1'b1, 1'b0);
        repeat (8) @(negedge sclk);
        cfg_start = 1'b1;
        cfg_data  = 42'h2DE_ADBE_EF01;
        @(negedge sclk);
        cfg_start = 1'b0;
        wait_for(1'b0, 10, 40, lat, wat);
        check("ignored_rd_latency", 64'(lat), 64'd22);
        repeat (60) @(negedge sclk);
        check("ignored_cfg_done", 64'(n_cfgd - cnt0), 64'd0);
        check("ignored_write_cfg", 64'(n_wcfg - cnt1), 64'd0);

        // Reset at cnt=20 of a config write aborts it without touching cfg_out.
        cfg_keep = cfg_out;
        cnt1     = n_wcfg;
        cfg_data = 42'h123_4567_89AB;
        issue(1'b0, 1'b1);
        repeat (20) @(negedge sclk);
        check("abort_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_shift", 64'(shift), 64'd0);
        check("abort_serial_in", 64'(serial_in), 64'd0);
        check("abort_write_cfg", 64'(write_cfg), 64'd0);
        check("abort_rd_data", 64'(rd_data), 64'd0);
        @(negedge sclk);
        rst = 1'b0;
        repeat (50) @(negedge sclk);
        check("abort_write_count", 64'(n_wcfg - cnt1), 64'd0);
        check("abort_cfg_out", 64'(cfg_out), 64'(cfg_keep));

        // 1000 back-to-back readouts of random pixels.
        cnt0     = n_rdv;
        rd_start = 1'b1;
        for (int c = 0; c < 1000 * 23 && (n_rdv - cnt0) < 1000; c++) begin
            @(negedge sclk);
            pixel_in = SREG_W'({$urandom(), $urandom()});
        end
        rd_start = 1'b0;
        check("b2b_rd_count", 64'(n_rdv - cnt0), 64'd1000);
        repeat (30) @(negedge sclk);

        // Random mix of both request types.
        for (int c = 0; c < 600; c++) begin
            @(negedge sclk);
            rd_start  = ($urandom_range(0, 9) == 0);
            cfg_start = ($urandom_range(0, 19) == 0);
            cfg_data  = SREG_W'({$urandom(), $urandom()});
            pixel_in  = SREG_W'({$urandom(), $urandom()});
        end
        rd_start  = 1'b0;
        cfg_start = 1'b0;
        repeat (120) @(negedge sclk);
        check("final_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
